// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared definitions for the switch debouncer: the 2-bit state encoding,
// the default stability window and a helper that sizes the qualification
// counter.
package debounce_pkg;

    // State encoding. Bit 1 is the debounced level and bit 0 marks a
    // qualification in progress, so both outputs come straight off flops.
    localparam logic [1:0] ST_ZERO  = 2'd0;
    localparam logic [1:0] ST_WAIT1 = 2'd1;
    localparam logic [1:0] ST_ONE   = 2'd2;
    localparam logic [1:0] ST_WAIT0 = 2'd3;

    typedef enum logic [1:0] {
        ZERO  = ST_ZERO,
        WAIT1 = ST_WAIT1,
        ONE   = ST_ONE,
        WAIT0 = ST_WAIT0
    } db_state_t;

    // 10 ms at 100 MHz.
    localparam int DEFAULT_STABLE_CYCLES = 1_000_000;
    localparam int DEFAULT_SYNC_STAGES   = 2;

    // Width needed to hold STABLE_CYCLES-1, never less than one bit.
    function automatic int cnt_width(input int stable_cycles);
        return (stable_cycles < 2) ? 1 : $clog2(stable_cycles);
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer
// Multi-flop synchronizer bringing one asynchronous bit into clk.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous, active-high; clears every stage to 0
//   d     in  asynchronous input bit
//   q     out synchronized bit (last stage)
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/debounce_fsm.sv
// debounce_fsm
// Debounces a raw mechanical switch. The input is synchronized, then every
// change must be seen on STABLE_CYCLES+1 consecutive sampled edges before
// the debounced level follows it; shorter runs are discarded entirely.
// Ports:
//   clk      in  system clock
//   reset    in  asynchronous, active-high
//   sw       in  raw, bouncing switch input (asynchronous to clk)
//   db_level out debounced level (flop output)
//   busy     out high while a transition is being qualified (flop output)
module debounce_fsm
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic busy
);

    localparam int              CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_CYCLES - 1);

    logic             w_sw_s;
    db_state_t        r_state;
    db_state_t        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw),
        .q     (w_sw_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ZERO;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // The first changed sample enters WAIT with the counter loaded; the
    // counter then has to run down to zero and one more matching sample is
    // needed, giving STABLE_CYCLES+1 samples in total. A contrary sample
    // aborts even when the counter has already reached zero.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ZERO: begin
                if (w_sw_s) begin
                    w_state_next = WAIT1;
                    w_cnt_next   = CNT_LOAD;
                end
            end
            WAIT1: begin
                if (!w_sw_s) begin
                    w_state_next = ZERO;
                end else if (r_cnt == '0) begin
                    w_state_next = ONE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ONE: begin
                if (!w_sw_s) begin
                    w_state_next = WAIT0;
                    w_cnt_next   = CNT_LOAD;
                end
            end
            WAIT0: begin
                if (w_sw_s) begin
                    w_state_next = ONE;
                end else if (r_cnt == '0) begin
                    w_state_next = ZERO;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_next = ZERO;
            end
        endcase
    end

    // The encoding puts each output on its own state bit, so the outputs
    // are plain flop outputs with no decode glitches.
    assign db_level = r_state[1];
    assign busy     = r_state[0];

endmodule

// File: tb/tb_debounce_fsm.sv
module tb_debounce_fsm;
    import debounce_pkg::*;

    localparam int STABLE = 4;
    localparam int SYNC   = DEFAULT_SYNC_STAGES;
    localparam int LAT    = SYNC + STABLE + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sw = 1'b0;
    logic db_level;
    logic busy;

    always #5 clk = ~clk;

    debounce_fsm #(
        .STABLE_CYCLES (STABLE),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .db_level (db_level),
        .busy     (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard: {db_level, busy} expected after each sampling edge.
    logic [1:0] exp_q[$];
    logic       m_lvl;
    int         m_run;

    // Reference behaviour: a change is accepted once the synchronized input
    // has differed from the current level for STABLE+1 consecutive samples;
    // busy means such a run is in progress.
    task automatic model_reset();
        exp_q.delete();
        m_lvl = 1'b0;
        m_run = 0;
        repeat (SYNC) exp_q.push_back(2'b00);
    endtask

    task automatic drive(input logic v);
        @(negedge clk);
        sw = v;
        if (v !== m_lvl) begin
            m_run++;
            if (m_run == STABLE + 1) begin
                m_lvl = v;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        exp_q.push_back({m_lvl, (m_run != 0)});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [1:0] e;
        int rise_i, busy_i;
        @(negedge clk);
        sw = 1'b1;
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({db_level, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_hold db_level,busy=%b required=00", {db_level, busy});
            end
        end
        #1;
        reset = 1'b0;
        model_reset();
        rise_i = 0;
        busy_i = 0;
        for (int i = 1; i <= 12; i++) begin
            drive(1'b1);
            e = exp_q.pop_front();
            n_cmp++;
            if ({db_level, busy} !== e) begin
                n_fail++;
                $display("FAIL reset_release edge=%0d db_level,busy=%b required=%b", i, {db_level, busy}, e);
            end
            if (busy && busy_i == 0) busy_i = i;
            if (db_level && rise_i == 0) rise_i = i;
        end
        n_cmp++;
        if (busy_i !== SYNC + 1) begin
            n_fail++;
            $display("FAIL reset_busy_edge got=%0d required=%0d", busy_i, SYNC + 1);
        end
        n_cmp++;
        if (rise_i !== LAT) begin
            n_fail++;
            $display("FAIL reset_rise_edge got=%0d required=%0d", rise_i, LAT);
        end
        $display("test_reset done: busy edge %0d, rise edge %0d", busy_i, rise_i);
    endtask

    task automatic test_glitch();
        logic pat[$];
        logic [1:0] e;
        int busy_cnt, db_high;
        repeat (8) pat.push_back(1'b0);
        repeat (STABLE) pat.push_back(1'b1);
        repeat (8) pat.push_back(1'b0);
        busy_cnt = 0;
        db_high = 0;
        foreach (pat[i]) begin
            drive(pat[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if ({db_level, busy} !== e) begin
                n_fail++;
                $display("FAIL glitch step=%0d db_level,busy=%b required=%b", i + 1, {db_level, busy}, e);
            end
            if (i >= 8) begin
                if (busy) busy_cnt++;
                if (db_level) db_high++;
            end
        end
        n_cmp++;
        if (db_high !== 0 || busy_cnt !== STABLE) begin
            n_fail++;
            $display("FAIL glitch_window db_high=%0d busy_cycles=%0d required 0 and %0d", db_high, busy_cnt, STABLE);
        end
        $display("test_glitch done: busy cycles %0d", busy_cnt);
    endtask

    task automatic test_accept();
        logic pat[$];
        logic [1:0] e;
        int rise_i, fall_i;
        repeat (STABLE + 1) pat.push_back(1'b1);
        repeat (10) pat.push_back(1'b0);
        rise_i = 0;
        fall_i = 0;
        foreach (pat[i]) begin
            drive(pat[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if ({db_level, busy} !== e) begin
                n_fail++;
                $display("FAIL accept step=%0d db_level,busy=%b required=%b", i + 1, {db_level, busy}, e);
            end
            if (db_level && rise_i == 0) rise_i = i + 1;
            if (!db_level && rise_i != 0 && fall_i == 0) fall_i = i + 1;
        end
        n_cmp++;
        if (rise_i !== LAT || fall_i !== STABLE + 1 + LAT) begin
            n_fail++;
            $display("FAIL accept_edges rise=%0d fall=%0d required %0d and %0d", rise_i, fall_i, LAT, STABLE + 1 + LAT);
        end
        $display("test_accept done: rise %0d fall %0d", rise_i, fall_i);
    endtask

    task automatic test_bounce();
        logic pat[$];
        logic [1:0] e;
        logic prev;
        int toggles, rise_i;
        for (int k = 0; k < 10; k++) pat.push_back((k % 2) == 0);
        repeat (12) pat.push_back(1'b1);
        toggles = 0;
        rise_i = 0;
        prev = db_level;
        foreach (pat[i]) begin
            drive(pat[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if ({db_level, busy} !== e) begin
                n_fail++;
                $display("FAIL bounce step=%0d db_level,busy=%b required=%b", i + 1, {db_level, busy}, e);
            end
            if (db_level !== prev) toggles++;
            if (db_level && rise_i == 0) rise_i = i + 1;
            prev = db_level;
        end
        n_cmp++;
        if (toggles !== 1 || rise_i !== 10 + LAT) begin
            n_fail++;
            $display("FAIL bounce_edges toggles=%0d rise=%0d required 1 and %0d", toggles, rise_i, 10 + LAT);
        end
        $display("test_bounce done: toggles %0d rise %0d", toggles, rise_i);
    endtask

    task automatic test_abort_cnt0();
        logic pat[$];
        logic [1:0] e;
        int bad_w1, bad_w0;
        repeat (8) pat.push_back(1'b0);        // 0..7   back to ZERO
        repeat (STABLE) pat.push_back(1'b1);   // 8..11  WAIT1 aborted at cnt==0
        repeat (6) pat.push_back(1'b0);        // 12..17
        repeat (8) pat.push_back(1'b1);        // 18..25 up to ONE
        repeat (STABLE) pat.push_back(1'b0);   // 26..29 WAIT0 aborted at cnt==0
        repeat (6) pat.push_back(1'b1);        // 30..35
        bad_w1 = 0;
        bad_w0 = 0;
        foreach (pat[i]) begin
            drive(pat[i]);
            e = exp_q.pop_front();
            n_cmp++;
            if ({db_level, busy} !== e) begin
                n_fail++;
                $display("FAIL abort step=%0d db_level,busy=%b required=%b", i + 1, {db_level, busy}, e);
            end
            if (i >= 8 && i < 18 && db_level) bad_w1++;
            if (i >= 26 && !db_level) bad_w0++;
        end
        n_cmp++;
        if (bad_w1 !== 0 || bad_w0 !== 0) begin
            n_fail++;
            $display("FAIL abort_level wait1_rises=%0d wait0_drops=%0d required 0 and 0", bad_w1, bad_w0);
        end
        $display("test_abort_cnt0 done");
    endtask

    task automatic test_reset_midway();
        logic [1:0] e;
        int db_high;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0);
            e = exp_q.pop_front();
            n_cmp++;
            if ({db_level, busy} !== e) begin
                n_fail++;
                $display("FAIL midreset_pre step=%0d db_level,busy=%b required=%b", i + 1, {db_level, busy}, e);
            end
        end
        n_cmp++;
        if ({db_level, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL midreset_wait0 db_level,busy=%b required=11", {db_level, busy});
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({db_level, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_async db_level,busy=%b required=00", {db_level, busy});
        end
        @(negedge clk);
        sw = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        db_high = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0);
            e = exp_q.pop_front();
            n_cmp++;
            if ({db_level, busy} !== e) begin
                n_fail++;
                $display("FAIL midreset_post step=%0d db_level,busy=%b required=%b", i + 1, {db_level, busy}, e);
            end
            if (db_level || busy) db_high++;
        end
        n_cmp++;
        if (db_high !== 0) begin
            n_fail++;
            $display("FAIL midreset_idle active_cycles=%0d required=0", db_high);
        end
        $display("test_reset_midway done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_glitch();
        test_accept();
        test_bounce();
        test_abort_cnt0();
        test_reset_midway();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
